// File: rtl/core_pkg.sv
// Shared core constants and the operand forward-select encoding.
// No logic, no latency, no flow control.
package core_pkg;
    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int CW     = 16;
    localparam int R_ZERO = 0;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_sel_e;
endpackage

// File: rtl/fwd_mux.sv
// Priority bypass select for one decode operand: R0, EX, MEM, WB, then register file.
// Purely combinational, zero latency; no backpressure (load-in-EX simply falls through).
module fwd_mux
    import core_pkg::*;
#(
    parameter int DW = core_pkg::DW,
    parameter int AW = core_pkg::AW
) (
    input  logic [AW-1:0] addr_i,
    input  logic          ex_live_i,
    input  logic          ex_rw_i,
    input  logic          ex_md_i,
    input  logic [AW-1:0] ex_da_i,
    input  logic [DW-1:0] ex_f_i,
    input  logic          m_valid_i,
    input  logic          m_rw_i,
    input  logic [AW-1:0] m_da_i,
    input  logic [DW-1:0] m_d_i,
    input  logic          w_valid_i,
    input  logic          w_rw_i,
    input  logic [AW-1:0] w_da_i,
    input  logic [DW-1:0] w_d_i,
    input  logic [DW-1:0] rf_i,
    output logic [DW-1:0] op_o
);
    fwd_sel_e sel;
    logic     ex_hit;
    logic     m_hit;
    logic     w_hit;

    always_comb begin
        ex_hit = ex_live_i & ex_rw_i & (ex_da_i == addr_i);
        m_hit  = m_valid_i & m_rw_i & (m_da_i == addr_i);
        w_hit  = w_valid_i & w_rw_i & (w_da_i == addr_i);

        // A load still in EX has no data yet; older stages or the RF win instead.
        sel = FWD_RF;
        if (addr_i == AW'(R_ZERO))  sel = FWD_ZERO;
        else if (ex_hit && !ex_md_i) sel = FWD_EX;
        else if (m_hit)              sel = FWD_MEM;
        else if (w_hit)              sel = FWD_WB;

        case (sel)
            FWD_ZERO: op_o = '0;
            FWD_EX:   op_o = ex_f_i;
            FWD_MEM:  op_o = m_d_i;
            FWD_WB:   op_o = w_d_i;
            default:  op_o = rf_i;
        endcase
    end
endmodule

// File: rtl/wb_forward_unit.sv
// MEM/WB pipeline, register-file write port, operand bypass and load-use stall detection.
// Write lands 2 edges after EX; no backpressure, stall is a combinational request to upstream.
module wb_forward_unit
    import core_pkg::*;
#(
    parameter int DW = core_pkg::DW,
    parameter int AW = core_pkg::AW,
    parameter int CW = core_pkg::CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic          ex_rw,
    input  logic [AW-1:0] ex_da,
    input  logic          ex_md,
    input  logic [DW-1:0] ex_f,
    input  logic          flush,
    input  logic [DW-1:0] mem_rdata,
    input  logic [AW-1:0] id_aa,
    input  logic [AW-1:0] id_ba,
    input  logic [DW-1:0] reg_a,
    input  logic [DW-1:0] reg_b,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          stall,
    output logic          RW,
    output logic [AW-1:0] DA,
    output logic [DW-1:0] BUS_D,
    output logic [CW-1:0] stall_cnt
);
    logic          m_valid_q, m_rw_q, m_md_q;
    logic [AW-1:0] m_da_q;
    logic [DW-1:0] m_f_q;
    logic [DW-1:0] m_d;
    logic          w_valid_q, w_rw_q;
    logic [AW-1:0] w_da_q;
    logic [DW-1:0] w_d_q;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          ex_live;

    assign ex_live = ex_valid & ~flush;
    assign m_d     = m_md_q ? mem_rdata : m_f_q;

    assign stall = ex_live & ex_rw & ex_md & (ex_da != AW'(R_ZERO)) &
                   ((ex_da == id_aa) | (ex_da == id_ba));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q   <= 1'b0;
            m_rw_q      <= 1'b0;
            m_md_q      <= 1'b0;
            m_da_q      <= '0;
            m_f_q       <= '0;
            w_valid_q   <= 1'b0;
            w_rw_q      <= 1'b0;
            w_da_q      <= '0;
            w_d_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            m_valid_q   <= ex_live;
            // Writes to R0 are dropped here so the port never asserts with DA=0.
            m_rw_q      <= ex_rw & (ex_da != AW'(R_ZERO));
            m_md_q      <= ex_md;
            m_da_q      <= ex_da;
            m_f_q       <= ex_f;
            w_valid_q   <= m_valid_q;
            w_rw_q      <= m_rw_q;
            w_da_q      <= m_da_q;
            w_d_q       <= m_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign RW        = w_valid_q & w_rw_q;
    assign DA        = w_da_q;
    assign BUS_D     = w_d_q;
    assign stall_cnt = stall_cnt_q;

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
        .addr_i    (id_aa),
        .ex_live_i (ex_live),
        .ex_rw_i   (ex_rw),
        .ex_md_i   (ex_md),
        .ex_da_i   (ex_da),
        .ex_f_i    (ex_f),
        .m_valid_i (m_valid_q),
        .m_rw_i    (m_rw_q),
        .m_da_i    (m_da_q),
        .m_d_i     (m_d),
        .w_valid_i (w_valid_q),
        .w_rw_i    (w_rw_q),
        .w_da_i    (w_da_q),
        .w_d_i     (w_d_q),
        .rf_i      (reg_a),
        .op_o      (op_a)
    );

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
        .addr_i    (id_ba),
        .ex_live_i (ex_live),
        .ex_rw_i   (ex_rw),
        .ex_md_i   (ex_md),
        .ex_da_i   (ex_da),
        .ex_f_i    (ex_f),
        .m_valid_i (m_valid_q),
        .m_rw_i    (m_rw_q),
        .m_da_i    (m_da_q),
        .m_d_i     (m_d),
        .w_valid_i (w_valid_q),
        .w_rw_i    (w_rw_q),
        .w_da_i    (w_da_q),
        .w_d_i     (w_d_q),
        .rf_i      (reg_b),
        .op_o      (op_b)
    );
endmodule

// File: tb/tb_wb_forward_unit.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor compares them.
module tb_wb_forward_unit;
    localparam int K_OPA = 0, K_OPB = 1, K_STALL = 2, K_RW = 3, K_DA = 4, K_BUSD = 5, K_CNT = 6;
    localparam logic [31:0] RA = 32'hAAAA_0001;
    localparam logic [31:0] RB = 32'hBBBB_0002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_rw, ex_md, flush;
    logic [4:0]  ex_da, id_aa, id_ba, DA;
    logic [31:0] ex_f, mem_rdata, reg_a, reg_b, op_a, op_b, BUS_D;
    logic        stall, RW;
    logic [15:0] stall_cnt;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t  q[$];
    int    cyc = 0;
    int    checks = 0;
    int    passes = 0;
    string kname[7] = '{"op_a", "op_b", "stall", "RW", "DA", "BUS_D", "stall_cnt"};

    wb_forward_unit dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_da(ex_da),
        .ex_md(ex_md), .ex_f(ex_f), .flush(flush), .mem_rdata(mem_rdata),
        .id_aa(id_aa), .id_ba(id_ba), .reg_a(reg_a), .reg_b(reg_b),
        .op_a(op_a), .op_b(op_b), .stall(stall), .RW(RW), .DA(DA), .BUS_D(BUS_D),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dut_out(input int k);
        case (k)
            K_OPA:   return op_a;
            K_OPB:   return op_b;
            K_STALL: return {31'b0, stall};
            K_RW:    return {31'b0, RW};
            K_DA:    return {27'b0, DA};
            K_BUSD:  return BUS_D;
            default: return {16'b0, stall_cnt};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                logic [31:0] act;
                act = dut_out(q[i].kind);
                checks++;
                if (q[i].cyc < cyc)
                    $display("FAIL %s cyc=%0d: comparison missed its cycle, required %h",
                             kname[q[i].kind], q[i].cyc, q[i].val);
                else if (act !== q[i].val)
                    $display("FAIL %s cyc=%0d: got %h, required %h",
                             kname[q[i].kind], cyc, act, q[i].val);
                else
                    passes++;
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int dc, input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc + dc;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic rw, input logic md,
                            input logic [4:0] da, input logic [31:0] f);
        ex_valid = v;
        ex_rw    = rw;
        ex_md    = md;
        ex_da    = da;
        ex_f     = f;
        flush    = 1'b0;
    endtask

    task automatic idle();
        drive_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        id_aa     = 5'd0;
        id_ba     = 5'd0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        reg_a = RA;
        reg_b = RB;
        idle();
        step();
        // Reset state
        expect_at(0, K_RW, 0); expect_at(0, K_DA, 0); expect_at(0, K_BUSD, 0); expect_at(0, K_CNT, 0);
        step();
        rst_n = 1'b1;
        step();

        // Plain write of R5: port active exactly two cycles later
        drive_ex(1, 1, 0, 5'd5, 32'h1234);
        expect_at(0, K_RW, 0); expect_at(1, K_RW, 0);
        expect_at(2, K_RW, 1); expect_at(2, K_DA, 5); expect_at(2, K_BUSD, 32'h1234);
        expect_at(3, K_RW, 0);
        step(); idle(); step(); step(); step(); step();

        // Dependence chain on R3 through EX, MEM, WB, then register file
        drive_ex(1, 1, 0, 5'd3, 32'h10); id_aa = 5'd3;
        expect_at(0, K_OPA, 32'h10);
        step(); drive_ex(0, 0, 0, 5'd0, 32'h999);
        expect_at(0, K_OPA, 32'h10);
        step(); expect_at(0, K_OPA, 32'h10); expect_at(0, K_RW, 1); expect_at(0, K_DA, 3);
        step(); expect_at(0, K_OPA, RA);
        step(); idle(); step(); step();

        // Priority on R7: youngest wins; R0 operand always zero
        drive_ex(1, 1, 0, 5'd7, 32'hA); step();
        drive_ex(1, 1, 0, 5'd7, 32'hB); step();
        drive_ex(1, 1, 0, 5'd7, 32'hC); id_ba = 5'd7; id_aa = 5'd0;
        expect_at(0, K_OPB, 32'hC); expect_at(0, K_OPA, 32'h0);
        step(); drive_ex(0, 0, 0, 5'd0, 32'h0);
        expect_at(0, K_OPB, 32'hC);
        step(); expect_at(0, K_OPB, 32'hC); expect_at(0, K_BUSD, 32'hC);
        step(); idle();
        drive_ex(1, 1, 0, 5'd0, 32'h77);
        expect_at(0, K_OPA, 32'h0); expect_at(0, K_OPB, 32'h0); expect_at(2, K_RW, 0);
        step(); idle(); step(); step(); step();

        // Load-use on R9: one stall cycle, then MEM forwards load data
        drive_ex(1, 1, 1, 5'd9, 32'h100); id_aa = 5'd9;
        expect_at(0, K_STALL, 1); expect_at(0, K_OPA, RA); expect_at(0, K_CNT, 0);
        step(); drive_ex(0, 0, 0, 5'd0, 32'h0); mem_rdata = 32'hDEAD;
        expect_at(0, K_STALL, 0); expect_at(0, K_OPA, 32'hDEAD); expect_at(0, K_CNT, 1);
        step(); mem_rdata = 32'hBEEF;
        expect_at(0, K_OPA, 32'hDEAD); expect_at(0, K_RW, 1); expect_at(0, K_DA, 9);
        expect_at(0, K_BUSD, 32'hDEAD);
        step(); idle(); step(); step();

        // Flushed load to R4 with hazard present: no stall, no forward, no write
        drive_ex(1, 1, 1, 5'd4, 32'h44); flush = 1'b1; id_aa = 5'd4;
        expect_at(0, K_STALL, 0); expect_at(0, K_OPA, RA);
        step(); drive_ex(0, 0, 0, 5'd0, 32'h0);
        expect_at(0, K_OPA, RA); expect_at(0, K_CNT, 1);
        step(); expect_at(0, K_RW, 0); expect_at(0, K_OPA, RA);
        step(); idle(); step();

        // Reset with MEM and WB both occupied
        drive_ex(1, 1, 0, 5'd6, 32'h66); step();
        drive_ex(1, 1, 0, 5'd8, 32'h88); step();
        idle(); id_aa = 5'd8; rst_n = 1'b0;
        expect_at(0, K_RW, 1); expect_at(0, K_DA, 6); expect_at(0, K_OPA, 32'h88);
        step(); expect_at(0, K_RW, 0); expect_at(0, K_CNT, 0); expect_at(0, K_OPA, RA);
        step(); rst_n = 1'b1; expect_at(0, K_RW, 0);
        step(); expect_at(0, K_RW, 0); expect_at(0, K_DA, 0);
        step(); idle(); step();

        // Continuous stall: counter saturates at 0xFFFF and holds
        drive_ex(1, 1, 1, 5'd9, 32'h0); id_aa = 5'd9;
        expect_at(0, K_STALL, 1); expect_at(0, K_CNT, 0); expect_at(1, K_CNT, 1);
        expect_at(65534, K_CNT, 32'hFFFE); expect_at(65535, K_CNT, 32'hFFFF);
        expect_at(65541, K_CNT, 32'hFFFF);
        repeat (65541) step();
        idle();
        expect_at(0, K_STALL, 0); expect_at(1, K_CNT, 32'hFFFF);
        step(); step(); step();

        if (q.size() != 0) begin
            checks += q.size();
            $display("FAIL scoreboard: %0d expectations never compared, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/wb_forward_unit.md
Name: wb_forward_unit

Overview:
- Write-back and bypass controller for the pipelined RISC core; it is the initiator that drives the register file write port (RW, DA, BUS_D).
- Carries EX-stage results through registered MEM and WB stages and selects load data in MEM.
- Forwards in-flight results onto decode-stage operands so they need not wait for the write to land.
- Detects load-use hazards, raises a stall and counts stall cycles.

Parameters:
- DW, 32, data width of results and operands
- AW, 5, register address width (2^AW registers, R0 hard-wired zero)
- CW, 16, width of saturating stall counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_rw  in  1  EX instruction writes a register
- ex_da  in  AW  EX destination register
- ex_md  in  1  EX instruction is a load (result comes from memory in MEM)
- ex_f  in  DW  EX ALU result
- flush  in  1  kill the EX instruction (branch taken)
- mem_rdata  in  DW  data-memory read data, valid in cycle the load occupies MEM
- id_aa  in  AW  decode operand A address (also drives register file AA)
- id_ba  in  AW  decode operand B address (also drives register file BA)
- reg_a  in  DW  register file REG_A
- reg_b  in  DW  register file REG_B
- op_a  out  DW  forwarded operand A
- op_b  out  DW  forwarded operand B
- stall  out  1  load-use hazard; decode holds, upstream injects EX bubble
- RW  out  1  register file write enable
- DA  out  AW  register file write address
- BUS_D  out  DW  register file write data
- stall_cnt  out  CW  saturating count of stall cycles

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at edge):
  - clears m_valid, m_rw, m_md, w_valid, w_rw;
  - clears m_da, w_da, m_f, w_d and stall_cnt;
  - RW=0, DA=0, BUS_D=0 from the first edge with rst_n=0.
- MEM capture, each edge:
  - m_valid <= ex_valid & ~flush;
  - m_rw <= ex_rw & (ex_da != 0);
  - m_da, m_md, m_f <= EX values.
- MEM data: m_d = m_md ? mem_rdata : m_f (combinational).
- WB capture, each edge:
  - w_valid <= m_valid, w_rw <= m_rw, w_da <= m_da, w_d <= m_d.
- Write port:
  - RW = w_valid & w_rw, DA = w_da, BUS_D = w_d (registered, no combinational path).
- Write latency: EX result is written 2 edges after EX, i.e. RW high in cycle n+2 for EX in cycle n.
- Match definitions, per operand address X:
  - ex_hit = ex_valid & ~flush & ex_rw & ex_da==X
  - m_hit = m_valid & m_rw & m_da==X
  - w_hit = w_valid & w_rw & w_da==X
- Forward priority for op_a/op_b (first true wins):
  - X==0 -> 0
  - ex_hit & ~ex_md -> ex_f
  - m_hit -> m_d
  - w_hit -> w_d
  - else -> reg_a / reg_b
- The WB forward covers the same cycle the register file is written.
- Load in EX: an ex_hit with ex_md=1 is not forwarded; the selection falls through to the MEM, WB or register value.
- stall = (ex_valid & ~flush & ex_rw & ex_md & ex_da!=0) & (ex_da==id_aa | ex_da==id_ba).
  - stall is purely combinational and always 1 cycle per hazard, given the upstream bubble.
  - After the bubble the load sits in MEM and is forwarded via m_d.
- flush=1 with stall conditions true -> stall=0 and no forward from EX.
- stall_cnt increments at each edge where stall=1; it saturates at all-ones and never wraps.
- ex_da==0 with ex_rw=1: treated as no write; RW never asserts with DA=0.
- Reset mid-pipeline: in-flight M/W instructions are discarded and no write occurs after reset.

Decomposition:
- Shared package core_pkg:
  - DW/AW constants and R_ZERO = 0;
  - forward-select enum {FWD_ZERO, FWD_EX, FWD_MEM, FWD_WB, FWD_RF}.
- One sub-module fwd_mux: combinational priority select plus match logic for one operand, instantiated twice (A and B).
- Pipeline registers, stall logic and counter stay in wb_forward_unit.

Test Plan:
- Reset, then EX writes R5=0x1234 (ex_valid=1, ex_rw=1, ex_md=0) -> RW=1, DA=5, BUS_D=0x1234 exactly 2 cycles later; RW=0 otherwise.
- Back-to-back dependence on R3, issued in successive cycles:
  - ADD R3=0x10, then id_aa=3 -> op_a=0x10 from EX;
  - next cycle op_a=0x10 from MEM;
  - next cycle op_a=0x10 from WB;
  - after that op_a=reg_a.
- Priority: R7 written 0xA in WB, 0xB in MEM, 0xC in EX, id_ba=7 -> op_b=0xC; with id_aa=0 -> op_a=0 despite any hits on R0.
- Load-use:
  - load R9 in EX with id_aa=9 -> stall=1 for 1 cycle, stall_cnt 0->1;
  - after the bubble, with mem_rdata=0xDEAD -> op_a=0xDEAD.
- Flush: ex_valid=1, ex_rw=1, ex_da=4, flush=1 -> no forward, stall=0, and no RW for R4 two cycles later.
- Reset mid-operation and saturation:
  - rst_n=0 with M/W valid -> RW=0 from the first edge with rst_n=0, and thereafter;
  - force continuous stall for 2^16+5 cycles (CW=16) -> stall_cnt holds 0xFFFF.
